// File: rtl/ej10_tp1_alu_if.sv
// ----------------------------------------------------------------------------
// ej10_tp1_alu_if
// Operand/result bus of the execute-stage ALU.
//
//   OPCODE  [OPCODE_BUS-1:0]  function code            (master -> slave)
//   OP1     [DATA_BUS-1:0]    first operand A          (master -> slave)
//   OP2     [DATA_BUS-1:0]    second operand B / shift (master -> slave)
//   OUT     [DATA_BUS-1:0]    registered result        (slave -> master)
//   ZERO                      registered, OUT == 0     (slave -> master)
//   CARRY                     registered carry/borrow  (slave -> master)
//   OVFL                      registered signed ovfl   (slave -> master)
//   ILLEGAL                   registered bad opcode    (slave -> master)
//
// The master is whatever feeds the stage (switches, decode); the slave is
// the ALU itself.
// ----------------------------------------------------------------------------
interface ej10_tp1_alu_if #(
    parameter int DATA_BUS   = 8,
    parameter int OPCODE_BUS = 6
);
    logic [OPCODE_BUS-1:0] OPCODE;
    logic [DATA_BUS-1:0]   OP1;
    logic [DATA_BUS-1:0]   OP2;
    logic [DATA_BUS-1:0]   OUT;
    logic                  ZERO;
    logic                  CARRY;
    logic                  OVFL;
    logic                  ILLEGAL;

    modport master (
        output OPCODE, OP1, OP2,
        input  OUT, ZERO, CARRY, OVFL, ILLEGAL
    );

    modport slave (
        input  OPCODE, OP1, OP2,
        output OUT, ZERO, CARRY, OVFL, ILLEGAL
    );
endinterface

// File: rtl/ej10_tp1_alu.sv
// ----------------------------------------------------------------------------
// ej10_tp1_alu
// Execute-stage integer ALU of the teaching processor. Applies one of eight
// MIPS-style function codes to two operands; result and status flags are
// registered, giving a one-cycle latency and a throughput of one op per clock.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   synchronous active-low reset (clears result and all flags)
//   bus    slave modport of ej10_tp1_alu_if
//            OPCODE/OP1/OP2 in, OUT/ZERO/CARRY/OVFL/ILLEGAL out (all flopped)
//
// Parameters:
//   DATA_BUS    operand/result width (>= 2)
//   OPCODE_BUS  function-code width
// ----------------------------------------------------------------------------
module ej10_tp1_alu #(
    parameter int DATA_BUS   = 8,
    parameter int OPCODE_BUS = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    ej10_tp1_alu_if.slave      bus
);

    localparam int MSB = DATA_BUS - 1;

    // Function codes (MIPS "funct" field values).
    typedef enum logic [OPCODE_BUS-1:0] {
        OP_SRL = OPCODE_BUS'(6'b000010),
        OP_SRA = OPCODE_BUS'(6'b000011),
        OP_ADD = OPCODE_BUS'(6'b100000),
        OP_SUB = OPCODE_BUS'(6'b100010),
        OP_AND = OPCODE_BUS'(6'b100100),
        OP_OR  = OPCODE_BUS'(6'b100101),
        OP_XOR = OPCODE_BUS'(6'b100110),
        OP_NOR = OPCODE_BUS'(6'b100111)
    } alu_op_e;

    // ------------------------------------------------------------------------
    // Arithmetic unit
    // ------------------------------------------------------------------------
    // Both operands are zero-extended by one bit so the extra MSB of the sum
    // is the carry-out and the extra MSB of the difference is the borrow
    // (set exactly when OP1 < OP2 unsigned).
    logic [DATA_BUS:0] add_w;
    logic [DATA_BUS:0] sub_w;
    logic              add_ovf;
    logic              sub_ovf;

    assign add_w = {1'b0, bus.OP1} + {1'b0, bus.OP2};
    assign sub_w = {1'b0, bus.OP1} - {1'b0, bus.OP2};

    // ADD overflows when like-signed operands produce a result of the other
    // sign; SUB overflows when unlike-signed operands produce a result whose
    // sign differs from the minuend.
    assign add_ovf = (bus.OP1[MSB] == bus.OP2[MSB]) && (add_w[MSB] != bus.OP1[MSB]);
    assign sub_ovf = (bus.OP1[MSB] != bus.OP2[MSB]) && (sub_w[MSB] != bus.OP1[MSB]);

    // ------------------------------------------------------------------------
    // Shifter
    // ------------------------------------------------------------------------
    // The full OP2 value is the shift amount. SV shifts already saturate:
    // a logical shift by >= DATA_BUS yields 0 and an arithmetic shift by
    // >= DATA_BUS yields all copies of the sign bit, so no clamp is needed.
    logic signed [DATA_BUS-1:0] op1_s;
    logic        [DATA_BUS-1:0] srl_w;
    logic        [DATA_BUS-1:0] sra_w;

    assign op1_s = $signed(bus.OP1);
    assign srl_w = bus.OP1 >> bus.OP2;
    assign sra_w = op1_s >>> bus.OP2;

    // ------------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------------
    logic [DATA_BUS-1:0] out_d,     out_q;
    logic                carry_d,   carry_q;
    logic                ovfl_d,    ovfl_q;
    logic                illegal_d, illegal_q;
    logic                zero_d,    zero_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        out_d     = '0;
        carry_d   = 1'b0;
        ovfl_d    = 1'b0;
        illegal_d = 1'b0;

        case (bus.OPCODE)
            OP_ADD: begin
                out_d   = add_w[MSB:0];
                carry_d = add_w[DATA_BUS];
                ovfl_d  = add_ovf;
            end
            OP_SUB: begin
                out_d   = sub_w[MSB:0];
                carry_d = sub_w[DATA_BUS];
                ovfl_d  = sub_ovf;
            end
            OP_AND:  out_d = bus.OP1 & bus.OP2;
            OP_OR:   out_d = bus.OP1 | bus.OP2;
            OP_XOR:  out_d = bus.OP1 ^ bus.OP2;
            OP_NOR:  out_d = ~(bus.OP1 | bus.OP2);
            OP_SRA:  out_d = sra_w;
            OP_SRL:  out_d = srl_w;
            default: illegal_d = 1'b1;   // result stays 0, flags stay 0
        endcase

        // Derived from the selected result, so an illegal code reports ZERO=1.
        zero_d = (out_d == '0);
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the block's behaviour does not depend on simulator process order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // Reset clears ZERO too, even though OUT is 0 at that point.
            out_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovfl_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovfl_q    <= ovfl_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs come straight from flops: no input-to-output combinational path.
    assign bus.OUT     = out_q;
    assign bus.ZERO    = zero_q;
    assign bus.CARRY   = carry_q;
    assign bus.OVFL    = ovfl_q;
    assign bus.ILLEGAL = illegal_q;

endmodule

// File: tb/tb_ej10_tp1_alu.sv
// ----------------------------------------------------------------------------
// tb_ej10_tp1_alu
// Self-checking bench for ej10_tp1_alu (DATA_BUS = 8, OPCODE_BUS = 6).
// A behavioural model computes the expected registered outputs from the
// inputs present at each rising edge using plain integer arithmetic; a
// compare process checks every cycle. Directed cases with hand-computed
// literals pin the model, followed by a back-to-back sweep and a randomized
// run with occasional resets and illegal codes.
// ----------------------------------------------------------------------------
module tb_ej10_tp1_alu;

    localparam logic [5:0] C_ADD = 6'b100000;
    localparam logic [5:0] C_SUB = 6'b100010;
    localparam logic [5:0] C_AND = 6'b100100;
    localparam logic [5:0] C_OR  = 6'b100101;
    localparam logic [5:0] C_XOR = 6'b100110;
    localparam logic [5:0] C_NOR = 6'b100111;
    localparam logic [5:0] C_SRA = 6'b000011;
    localparam logic [5:0] C_SRL = 6'b000010;

    logic [5:0] codes [8] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SRA, C_SRL};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ej10_tp1_alu_if #(.DATA_BUS(8), .OPCODE_BUS(6)) bus ();

    ej10_tp1_alu #(.DATA_BUS(8), .OPCODE_BUS(6)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        bit z;
        bit c;
        bit v;
        bit il;
    } res_t;

    // Expected outputs after an edge, from the values sampled at that edge.
    function automatic res_t model(bit rstn, logic [5:0] op, int a, int b);
        res_t r;
        int   sa;
        int   sb;
        r  = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        if (!rstn) return r;
        case (op)
            C_ADD: begin
                r.out = (a + b) % 256;
                r.c   = (a + b) > 255;
                r.v   = (sa + sb > 127) || (sa + sb < -128);
            end
            C_SUB: begin
                r.out = (a - b + 256) % 256;
                r.c   = a < b;
                r.v   = (sa - sb > 127) || (sa - sb < -128);
            end
            C_AND: r.out = a & b;
            C_OR:  r.out = a | b;
            C_XOR: r.out = a ^ b;
            C_NOR: r.out = (~(a | b)) & 255;
            C_SRA: r.out = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
            C_SRL: r.out = (b >= 8) ? 0 : (a >> b);
            default: r.il = 1'b1;
        endcase
        r.z = (r.out == 0);
        return r;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        res_t e;
        e = model(rst_n, bus.OPCODE, int'(bus.OP1), int'(bus.OP2));
        #1;
        check("model_out",     32'(bus.OUT),     32'(e.out));
        check("model_zero",    32'(bus.ZERO),    32'(e.z));
        check("model_carry",   32'(bus.CARRY),   32'(e.c));
        check("model_ovfl",    32'(bus.OVFL),    32'(e.v));
        check("model_illegal", 32'(bus.ILLEGAL), 32'(e.il));
    end

    task automatic drive(bit rn, logic [5:0] op, logic [7:0] a, logic [7:0] b);
        @(negedge clk);
        rst_n      = rn;
        bus.OPCODE = op;
        bus.OP1    = a;
        bus.OP2    = b;
    endtask

    // Directed case: apply one op and compare against literal expectations.
    task automatic op_check(string nm, logic [5:0] op, logic [7:0] a, logic [7:0] b,
                            int eo, bit ez, bit ec, bit ev, bit ei);
        drive(1'b1, op, a, b);
        @(posedge clk);
        #2;
        check({nm, "_out"},     32'(bus.OUT),     32'(eo));
        check({nm, "_zero"},    32'(bus.ZERO),    32'(ez));
        check({nm, "_carry"},   32'(bus.CARRY),   32'(ec));
        check({nm, "_ovfl"},    32'(bus.OVFL),    32'(ev));
        check({nm, "_illegal"}, 32'(bus.ILLEGAL), 32'(ei));
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.OPCODE = C_ADD;
        bus.OP1    = 8'd2;
        bus.OP2    = 8'd8;

        // Reset held over two edges with an ADD pending.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check("rst_out",  32'(bus.OUT), 32'd0);
            check("rst_flags", {28'd0, bus.ZERO, bus.CARRY, bus.OVFL, bus.ILLEGAL}, 32'd0);
        end

        // First edge after release loads the pending ADD.
        op_check("release_add", C_ADD, 8'd2,   8'd8,   10,  0, 0, 0, 0);
        op_check("sub_19_4",    C_SUB, 8'd19,  8'd4,   15,  0, 0, 0, 0);
        op_check("add_carry",   C_ADD, 8'd200, 8'd100, 44,  0, 1, 0, 0);
        op_check("add_ovfl",    C_ADD, 8'd100, 8'd100, 200, 0, 0, 1, 0);
        op_check("sub_borrow",  C_SUB, 8'd4,   8'd19,  241, 0, 1, 0, 0);
        op_check("sub_zero",    C_SUB, 8'd5,   8'd5,   0,   1, 0, 0, 0);
        op_check("and",         C_AND, 8'd21,  8'd1,   1,   0, 0, 0, 0);
        op_check("or",          C_OR,  8'd33,  8'd10,  43,  0, 0, 0, 0);
        op_check("xor",         C_XOR, 8'd55,  8'd27,  44,  0, 0, 0, 0);
        op_check("nor",         C_NOR, 8'd30,  8'd7,   224, 0, 0, 0, 0);
        op_check("sra_3",       C_SRA, 8'd175, 8'd3,   245, 0, 0, 0, 0);
        op_check("srl_3",       C_SRL, 8'd175, 8'd3,   21,  0, 0, 0, 0);
        op_check("sra_9",       C_SRA, 8'd175, 8'd9,   255, 0, 0, 0, 0);
        op_check("srl_9",       C_SRL, 8'd175, 8'd9,   0,   1, 0, 0, 0);
        op_check("srl_0",       C_SRL, 8'd175, 8'd0,   175, 0, 0, 0, 0);
        op_check("sra_big",     C_SRA, 8'd100, 8'd200, 0,   1, 0, 0, 0);
        op_check("sub_ovfl",    C_SUB, 8'd128, 8'd1,   127, 0, 0, 1, 0);
        op_check("illegal",     6'b000000, 8'd5, 8'd3, 0,   1, 0, 0, 1);

        // Back-to-back: a different code every cycle, compared each edge.
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++)
                drive(1'b1, codes[k], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // Mid-stream reset has priority over the pending operation.
        drive(1'b0, C_ADD, 8'd1, 8'd1);

        // Randomized run: mostly legal codes, small shift amounts favoured.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            logic [7:0] b;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                             : codes[$urandom_range(0, 7)];
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10))
                                             : 8'($urandom_range(0, 255));
            drive($urandom_range(0, 49) != 0, op, 8'($urandom_range(0, 255)), b);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
